// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetch PC owner, imem req/ack master and in-order prefetch FIFO feeding IF/ID
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_data_i,
  output logic             inst_valid_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_pc_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, space;
  assign push         = state == REQ && imem_ack_i && !redirect_i;
  assign inst_valid_o = count_o != '0;
  assign pop          = inst_valid_o && !stall_i && !redirect_i;
  assign space        = ({1'b0, count_o} + {{CNT_W{1'b0}}, ~pop}) < (CNT_W + 1)'(DEPTH);
  assign inst_o       = inst_valid_o ? mem_inst[rd_ptr] : '0;
  assign inst_pc_o    = inst_valid_o ? mem_pc[rd_ptr] : '0;
  // fetch FSM: owns the fetch PC and keeps req/addr steady until the memory acks
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      pc          <= RESET_PC;
    end else begin
      if (redirect_i) pc <= redirect_pc_i;
      else if (push) pc <= pc + 32'd4;
      case (state)
        IDLE:
          if (start_i && !redirect_i && count_o < CNT_W'(DEPTH)) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
          end
        REQ:
          if (imem_ack_i) begin
            if (!redirect_i && start_i && space) imem_addr_o <= pc + 32'd4;
            else begin
              imem_req_o <= 1'b0;
              state      <= IDLE;
            end
          end else if (redirect_i) state <= DRAIN;
        DRAIN:
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
  // queue bookkeeping; a redirect empties the queue and voids any pop that cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (redirect_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // entry storage needs no reset: count_o gates visibility
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_data_i;
      mem_pc[wr_ptr]   <= pc;
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed plus randomized check of if_prefetch_queue against a queue-based model
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  logic        clk_i = 0, rst_i = 0, start_i = 0, stall_i = 0, redirect_i = 0, imem_ack_i = 0;
  logic [31:0] redirect_pc_i = 0, imem_data_i = 0;
  logic        imem_req_o, inst_valid_o;
  logic [31:0] imem_addr_o, inst_o, inst_pc_o;
  logic [2:0]  count_o;
  int errors = 0, checks = 0;
  bit          m_req, m_drain;
  logic [31:0] m_addr, m_pc;
  logic [63:0] q[$];

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_drain = 0; m_addr = 0; m_pc = 0;
    q.delete();
  endtask

  task automatic check_model();
    check("req", imem_req_o, m_req);
    if (m_req) check("addr", imem_addr_o, m_addr);
    check("valid", inst_valid_o, q.size() != 0);
    check("inst", inst_o, q.size() != 0 ? q[0][31:0] : 32'h0);
    check("inst_pc", inst_pc_o, q.size() != 0 ? q[0][63:32] : 32'h0);
    check("count", count_o, q.size());
  endtask

  // one clock: drive inputs, advance the model by the fetch rules, compare at the falling edge
  task automatic step(input bit st, input bit sl, input bit rd, input logic [31:0] rpc, input bit ak);
    logic [31:0] d = $urandom;
    int sz = q.size();
    bit pop = sz > 0 && !sl && !rd;
    bit n_req = m_req, n_drain = m_drain;
    logic [31:0] n_addr = m_addr, n_pc = m_pc;
    start_i = st; stall_i = sl; redirect_i = rd; redirect_pc_i = rpc; imem_ack_i = ak; imem_data_i = d;
    if (pop) void'(q.pop_front());
    if (!m_req) begin
      if (st && !rd && sz < DEPTH) begin n_req = 1; n_addr = m_pc; end
    end else if (ak) begin
      n_req = 0; n_drain = 0;
      if (!m_drain && !rd) begin
        q.push_back({m_pc, d});
        n_pc = m_pc + 32'd4;
        if (st && sz + 1 - int'(pop) < DEPTH) begin n_req = 1; n_addr = m_pc + 32'd4; end
      end
    end else if (rd) n_drain = 1;
    if (rd) begin q.delete(); n_pc = rpc; end
    @(posedge clk_i);
    m_req = n_req; m_drain = n_drain; m_addr = n_addr; m_pc = n_pc;
    @(negedge clk_i);
    check_model();
  endtask

  initial begin
    model_reset();
    #1;
    check_model();
    check("rst_addr", imem_addr_o, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
    // fill to full under stall with a zero-wait memory
    step(1, 1, 0, 0, 1);
    check("fill_addr0", imem_addr_o, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step(1, 1, 0, 0, 1);
      check("fill_addr", imem_addr_o, 32'(i * 4));
    end
    step(1, 1, 0, 0, 1);
    check("full_count", count_o, 3'd4);
    check("full_noreq", imem_req_o, 1'b0);
    step(1, 1, 0, 0, 1);
    check("full_stay", imem_req_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("pop_pc", inst_pc_o, 32'(i * 4));
      step(0, 0, 0, 0, 0);
    end
    // slow memory: address held, data visible one cycle after ack
    step(0, 0, 1, 32'h0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("wait_addr", imem_addr_o, 32'h0);
      check("wait_valid", inst_valid_o, 1'b0);
    end
    step(0, 0, 0, 0, 1);
    check("ack_valid", inst_valid_o, 1'b1);
    check("ack_pc", inst_pc_o, 32'h0);
    step(0, 0, 0, 0, 0);
    // redirect while a fetch to 0x8 is outstanding
    step(0, 0, 1, 32'h8, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0);
    check("drain_req", imem_req_o, 1'b1);
    check("drain_addr", imem_addr_o, 32'h8);
    step(1, 1, 0, 0, 1);
    check("drain_count", count_o, 3'd0);
    step(1, 1, 0, 0, 0);
    check("redir_addr", imem_addr_o, 32'h40);
    // ack and redirect together discard the word
    step(1, 1, 0, 0, 1);
    step(1, 1, 1, 32'h80, 1);
    check("same_valid", inst_valid_o, 1'b0);
    step(1, 1, 0, 0, 0);
    check("same_addr", imem_addr_o, 32'h80);
    // push and pop in the same cycle at count 2
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("pp_count", count_o, 3'd2);
    check("pp_head", inst_pc_o, 32'h84);
    // fetch PC wraps at the top of the address space
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    check("wrap_addr", imem_addr_o, 32'h0);
    step(0, 1, 0, 0, 1);
    check("wrap_head", inst_pc_o, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) != 0);
    // asynchronous reset in the middle of a request
    for (int i = 0; i < 20 && !m_req; i++) step(1, 1, 0, 0, 0);
    check("pre_rst_req", imem_req_o, 1'b1);
    #2 rst_i = 0;
    #1;
    check("arst_req", imem_req_o, 1'b0);
    check("arst_count", count_o, 3'd0);
    check("arst_valid", inst_valid_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
    step(1, 0, 0, 0, 0);
    check("post_rst_req", imem_req_o, 1'b1);
    check("post_rst_addr", imem_addr_o, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
